// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI4-Stream packet transmitter.
package axis_pkg;

    typedef enum logic [0:0] {
        IDLE,
        PKT
    } tx_state_t;

    // Widest keep mask any supported TDATA width can need (512 / 8).
    localparam int unsigned MAX_KEEP_W = 64;

    function automatic int unsigned bytes_of(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Low min(rem, nbytes) bits set.
    function automatic logic [MAX_KEEP_W-1:0] keep_from_bytes(input logic [31:0] rem,
                                                             input int unsigned nbytes);
        logic [MAX_KEEP_W-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = (i < rem) && (i < nbytes);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_packet_tx_if.sv
// Downstream AXI4-Stream bus driven by axis_packet_tx.
interface axis_packet_tx_if
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 2
);
    localparam int unsigned KEEP_WIDTH = bytes_of(DATA_WIDTH);

    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_WIDTH-1:0] TDATA;
    logic [KEEP_WIDTH-1:0] TKEEP;
    logic [KEEP_WIDTH-1:0] TSTRB;
    logic                  TLAST;
    logic [ID_WIDTH-1:0]   TID;
    logic [DEST_WIDTH-1:0] TDEST;
    logic [USER_WIDTH-1:0] TUSER;

    modport master (
        output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        output TREADY
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head and registered write-ready.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = wr_valid_i && ready_q;
    assign pop  = rd_valid_o && rd_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
        // Head reloads when it leaves or when an empty FIFO takes its first word; the
        // incoming word bypasses the array when it lands exactly at the new head.
        if (pop || count_q == '0) begin
            if (count_d == '0) begin
                dout_d = '0;
            end else if (push && wr_ptr_q == rd_ptr_d) begin
                dout_d = wr_data_i;
            end else begin
                dout_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ready_q  <= (count_d != CntW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign wr_ready_o = ready_q;
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = dout_q;
    assign full_o     = (count_q == CntW'(DEPTH));
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/axis_packet_tx.sv
// AXI4-Stream packet transmitter: frames upstream beats into packets and buffers them.
// Define AXIS_TX_STATS_EN to add the stat_pkts/stat_beats counters and stat_clr.
module axis_packet_tx
    import axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  cfg_len_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_bytes,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    axis_packet_tx_if.master      m_axis,
`ifdef AXIS_TX_STATS_EN
    input  logic                  stat_clr,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_beats,
`endif
    output logic                  busy
);
    localparam int unsigned BYTES   = bytes_of(DATA_WIDTH);
    localparam int unsigned ENTRY_W = DATA_WIDTH + BYTES + 1 + USER_WIDTH + ID_WIDTH + DEST_WIDTH;

    tx_state_t             state_q, state_d;
    logic [ID_WIDTH-1:0]   pkt_id_q, pkt_id_d;
    logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
    logic                  pkt_mode_q, pkt_mode_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;

    logic [ID_WIDTH-1:0]   beat_id;
    logic [DEST_WIDTH-1:0] beat_dest;
    logic                  beat_mode;
    logic [LEN_WIDTH-1:0]  beat_rem;
    logic                  beat_last;
    logic [BYTES-1:0]      beat_keep;
    logic [MAX_KEEP_W-1:0] keep_full;

    logic                  push;
    logic                  tx_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;

    assign push = in_valid && in_ready;

    // Attributes of the beat on the input: live cfg at packet start, latched values after.
    always_comb begin
        beat_id   = pkt_id_q;
        beat_dest = pkt_dest_q;
        beat_mode = pkt_mode_q;
        beat_rem  = rem_q;
        if (state_q == IDLE) begin
            beat_id   = cfg_id;
            beat_dest = cfg_dest;
            beat_mode = cfg_len_mode;
            beat_rem  = (cfg_pkt_bytes == '0) ? LEN_WIDTH'(1) : cfg_pkt_bytes;
        end
        beat_last = beat_mode ? (32'(beat_rem) <= BYTES) : in_last;
        keep_full = keep_from_bytes(32'(beat_rem), BYTES);
        beat_keep = (beat_mode && beat_last) ? keep_full[BYTES-1:0] : '1;
    end

    if (BYTES < MAX_KEEP_W) begin : g_keep_tail
        logic unused_keep_tail;
        assign unused_keep_tail = ^keep_full[MAX_KEEP_W-1:BYTES];
    end

    always_comb begin
        state_d    = state_q;
        pkt_id_d   = pkt_id_q;
        pkt_dest_d = pkt_dest_q;
        pkt_mode_d = pkt_mode_q;
        rem_d      = rem_q;
        if (push) begin
            pkt_id_d   = beat_id;
            pkt_dest_d = beat_dest;
            pkt_mode_d = beat_mode;
            if (beat_last) begin
                state_d = IDLE;
                rem_d   = '0;
            end else begin
                state_d = PKT;
                rem_d   = (32'(beat_rem) > BYTES) ? LEN_WIDTH'(32'(beat_rem) - BYTES) : '0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            pkt_id_q   <= '0;
            pkt_dest_q <= '0;
            pkt_mode_q <= 1'b0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            pkt_id_q   <= pkt_id_d;
            pkt_dest_q <= pkt_dest_d;
            pkt_mode_q <= pkt_mode_d;
            rem_q      <= rem_d;
        end
    end

    assign fifo_din = {in_data, beat_keep, beat_last, in_user, beat_id, beat_dest};

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .wr_valid_i (in_valid),
        .wr_ready_o (in_ready),
        .wr_data_i  (fifo_din),
        .rd_valid_o (tx_valid),
        .rd_ready_i (m_axis.TREADY),
        .rd_data_o  (fifo_dout),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign m_axis.TVALID = tx_valid;
    assign {m_axis.TDATA, m_axis.TKEEP, m_axis.TLAST, m_axis.TUSER, m_axis.TID,
            m_axis.TDEST} = fifo_dout;
    assign m_axis.TSTRB  = m_axis.TKEEP;

    assign busy = (state_q == PKT) || !fifo_empty;

    // The registered ready must already be low whenever the buffer is full.
    a_no_ready_when_full: assert property (@(posedge ACLK) disable iff (!ARESETn)
        fifo_full |-> !in_ready);

`ifdef AXIS_TX_STATS_EN
    logic [31:0] stat_pkts_q;
    logic [31:0] stat_beats_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn || stat_clr) begin
            stat_pkts_q  <= '0;
            stat_beats_q <= '0;
        end else if (tx_valid && m_axis.TREADY) begin
            stat_beats_q <= stat_beats_q + 32'd1;
            if (m_axis.TLAST) stat_pkts_q <= stat_pkts_q + 32'd1;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_beats = stat_beats_q;
`endif

endmodule
